// File: rtl/ntt_reorder_pkg.sv
// Shared constants, index helpers and FSM state types for the NTT output bit-reversal reorder buffer.
package ntt_reorder_pkg;

    localparam int unsigned W_DEF = 32;
    localparam int unsigned P_DEF = 32;
    localparam int unsigned N_DEF = 512;
    localparam int unsigned BEATS = N_DEF / P_DEF;
    localparam int unsigned LOG2N = $clog2(N_DEF);

    typedef enum logic {W_IDLE, WRITING} wr_state_t;
    typedef enum logic {R_IDLE, READING} rd_state_t;

    // Reverse the low nbits of idx.
    function automatic int unsigned bitrev(input int unsigned idx, input int unsigned nbits);
        int unsigned r;
        r = 0;
        for (int unsigned b = 0; b < nbits; b++) begin
            if (idx[b]) begin
                r = r | (32'd1 << (nbits - 1 - b));
            end
        end
        return r;
    endfunction

    // Input beat holding natural index j.
    function automatic int unsigned src_beat(input int unsigned j,
                                             input int unsigned log2n = LOG2N,
                                             input int unsigned p = P_DEF);
        return bitrev(j, log2n) / p;
    endfunction

    // Input lane holding natural index j.
    function automatic int unsigned src_lane(input int unsigned j,
                                             input int unsigned log2n = LOG2N,
                                             input int unsigned p = P_DEF);
        return bitrev(j, log2n) % p;
    endfunction

endpackage

// File: rtl/reorder_bank.sv
// One frame of storage: whole-beat write port, per-lane arbitrary-index combinational read port.
module reorder_bank
    import ntt_reorder_pkg::*;
#(
    parameter int unsigned W = W_DEF,
    parameter int unsigned P = P_DEF,
    parameter int unsigned N = N_DEF
) (
    input  logic                                 clk,
    input  logic                                 we,
    input  logic [$clog2(N/P)-1:0]               wbeat,
    input  logic [P*W-1:0]                       wdata,
    input  logic [P-1:0][$clog2(N)-1:0]          raddr,
    output logic [P*W-1:0]                       rdata_c
);

    localparam int unsigned LW = $clog2(P);

    logic [W-1:0] mem [N];

    // Beat b occupies words b*P .. b*P+P-1.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < int'(P); l++) begin
                mem[{wbeat, LW'(l)}] <= wdata[l*W +: W];
            end
        end
    end

    always_comb begin
        rdata_c = '0;
        for (int l = 0; l < int'(P); l++) begin
            rdata_c[l*W +: W] = mem[raddr[l]];
        end
    end

endmodule

// File: rtl/ntt_output_bitrev_reorder.sv
// Ping-pong frame buffer turning bit-reversed NTT output beats into natural-order beats.
module ntt_output_bitrev_reorder
    import ntt_reorder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_PER_INPUT = W_DEF,
    parameter int unsigned INPUT_PER_CYCLE      = P_DEF,
    parameter int unsigned N                    = N_DEF
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_start,
    input  logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] in_data,
    output logic                                          out_start,
    output logic                                          out_valid,
    output logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] out_data
);

    localparam int unsigned W  = DATA_WIDTH_PER_INPUT;
    localparam int unsigned P  = INPUT_PER_CYCLE;
    localparam int unsigned NB = N / P;
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned LW = $clog2(P);
    localparam int unsigned BW = $clog2(NB);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

    wr_state_t      wstate;
    logic [BW-1:0]  wcnt;
    logic           wbank;
    rd_state_t      rstate;
    logic [BW-1:0]  rcnt;
    logic           rbank;
    logic [1:0]     full;

    logic                     wr_en_c;
    logic [BW-1:0]            wr_beat_c;
    logic                     wr_done_c;
    logic                     rd_emit_c;
    logic                     rd_first_c;
    logic                     rd_done_c;
    logic [BW-1:0]            rd_beat_c;
    logic [P-1:0][AW-1:0]     raddr_c;
    logic [P*W-1:0]           rdata0_c;
    logic [P*W-1:0]           rdata1_c;
    logic [P*W-1:0]           rdata_c;

    // Write-side decode; an in_start always (re)starts at beat 0.
    always_comb begin
        wr_en_c   = (wstate == WRITING) || in_start;
        wr_beat_c = in_start ? '0 : wcnt;
        wr_done_c = (wstate == WRITING) && !in_start && (wcnt == LAST_BEAT);
    end

    // Read-side decode; an idle reader emits beat 0 the same cycle it sees a full bank.
    always_comb begin
        rd_first_c = (rstate == R_IDLE) && full[rbank];
        rd_emit_c  = (rstate == READING) || rd_first_c;
        rd_beat_c  = (rstate == READING) ? rcnt : '0;
        rd_done_c  = (rstate == READING) && (rcnt == LAST_BEAT);
    end

    // Output lane l of beat b takes natural index b*P+l from its bit-reversed source word.
    always_comb begin
        raddr_c = '0;
        for (int l = 0; l < int'(P); l++) begin
            raddr_c[l] = {BW'(src_beat(32'({rd_beat_c, LW'(l)}), AW, P)),
                          LW'(src_lane(32'({rd_beat_c, LW'(l)}), AW, P))};
        end
    end

    reorder_bank #(.W(W), .P(P), .N(N)) u_bank0 (
        .clk     (clk),
        .we      (wr_en_c && !wbank),
        .wbeat   (wr_beat_c),
        .wdata   (in_data),
        .raddr   (raddr_c),
        .rdata_c (rdata0_c)
    );

    reorder_bank #(.W(W), .P(P), .N(N)) u_bank1 (
        .clk     (clk),
        .we      (wr_en_c && wbank),
        .wbeat   (wr_beat_c),
        .wdata   (in_data),
        .raddr   (raddr_c),
        .rdata_c (rdata1_c)
    );

    assign rdata_c = rbank ? rdata1_c : rdata0_c;

    // Write FSM: fill the current bank beat by beat, then hand it to the reader.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate <= W_IDLE;
            wcnt   <= '0;
            wbank  <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (in_start) begin
                        wstate <= WRITING;
                        wcnt   <= BW'(1);
                    end
                end
                WRITING: begin
                    if (in_start) begin
                        wcnt <= BW'(1);
                    end else if (wcnt == LAST_BEAT) begin
                        wstate <= W_IDLE;
                        wcnt   <= '0;
                        wbank  <= ~wbank;
                    end else begin
                        wcnt <= wcnt + BW'(1);
                    end
                end
                default: begin
                    wstate <= W_IDLE;
                    wcnt   <= '0;
                end
            endcase
        end
    end

    // Bank-full flags: set by the writer's last beat, cleared by the reader's last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (wr_done_c && (wbank == 1'(b))) begin
                    full[b] <= 1'b1;
                end else if (rd_done_c && (rbank == 1'(b))) begin
                    full[b] <= 1'b0;
                end
            end
        end
    end

    // Read FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate    <= R_IDLE;
            rcnt      <= '0;
            rbank     <= 1'b0;
            out_start <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_start <= rd_first_c;
            out_valid <= rd_emit_c;
            out_data  <= rd_emit_c ? rdata_c : '0;
            case (rstate)
                R_IDLE: begin
                    if (rd_first_c) begin
                        rstate <= READING;
                        rcnt   <= BW'(1);
                    end
                end
                READING: begin
                    if (rcnt == LAST_BEAT) begin
                        rstate <= R_IDLE;
                        rcnt   <= '0;
                        rbank  <= ~rbank;
                    end else begin
                        rcnt <= rcnt + BW'(1);
                    end
                end
                default: begin
                    rstate <= R_IDLE;
                    rcnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_output_bitrev_reorder.sv
// Scoreboard bench for the NTT output bit-reversal reorder buffer.
module tb_ntt_output_bitrev_reorder;

    localparam int unsigned W  = 32;
    localparam int unsigned P  = 32;
    localparam int unsigned N  = 512;
    localparam int unsigned NB = 16;
    localparam int unsigned FW = P * W;

    typedef struct packed {
        logic          start;
        logic [FW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_start = 1'b0;
    logic [FW-1:0] in_data = '0;
    logic          out_start;
    logic          out_valid;
    logic [FW-1:0] out_data;

    beat_t         sb[$];
    int            start_q[$];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            last_start_cyc = 0;
    logic [FW-1:0] cap [NB];
    int            cap_beat = 0;
    int            run_len = 0;
    int            last_run = 0;
    bit            mon_on = 1'b0;
    bit            dead_seen = 1'b0;
    logic [W-1:0]  frm [N];

    ntt_output_bitrev_reorder #(
        .DATA_WIDTH_PER_INPUT (W),
        .INPUT_PER_CYCLE      (P),
        .N                    (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_start  (in_start),
        .in_data   (in_data),
        .out_start (out_start),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bitrev9(input int j);
        logic [8:0] v;
        logic [8:0] r;
        v = 9'(j);
        r = {<<{v}};
        return int'(r);
    endfunction

    // Output monitor: pops the scoreboard on valid beats, checks idle cycles are zero.
    always @(negedge clk) begin
        if (mon_on) begin
            if (out_valid === 1'b1) begin
                beat_t e;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat at cycle %0d start=%b lane0 got %h", cyc, out_start, out_data[W-1:0]);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_start !== e.start) begin
                        int bad;
                        bad = 0;
                        for (int l = P - 1; l >= 0; l--) begin
                            if (out_data[l*W +: W] !== e.data[l*W +: W]) bad = l;
                        end
                        errors++;
                        $display("FAIL beat_data cycle %0d lane %0d got %h exp %h start got %b exp %b",
                                 cyc, bad, out_data[bad*W +: W], e.data[bad*W +: W], out_start, e.start);
                    end
                end
                if (out_start === 1'b1) begin
                    start_q.push_back(cyc);
                    cap_beat = 0;
                end
                if (cap_beat < int'(NB)) cap[cap_beat] = out_data;
                cap_beat++;
                for (int l = 0; l < int'(P); l++) begin
                    if (out_data[l*W +: W] === 32'h0000_DEAD) dead_seen = 1'b1;
                end
                run_len++;
            end else begin
                if (run_len != 0) last_run = run_len;
                run_len = 0;
                checks++;
                if (out_data !== '0 || out_start !== 1'b0 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_output cycle %0d valid %b start %b lane0 got %h exp 0", cyc, out_valid, out_start, out_data[W-1:0]);
                end
            end
        end
    end

    task automatic load_ramp(input int base);
        for (int i = 0; i < int'(N); i++) frm[i] = 32'(base + i);
    endtask

    task automatic load_const(input logic [W-1:0] v);
        for (int i = 0; i < int'(N); i++) frm[i] = v;
    endtask

    task automatic push_expected();
        for (int b = 0; b < int'(NB); b++) begin
            beat_t e;
            e.start = (b == 0);
            e.data  = '0;
            for (int l = 0; l < int'(P); l++) begin
                e.data[l*W +: W] = frm[bitrev9(b * int'(P) + l)];
            end
            sb.push_back(e);
        end
    endtask

    task automatic send_frame(input int nbeats, input bit push);
        if (push) push_expected();
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            in_start = (b == 0);
            if (b == 0) last_start_cyc = cyc + 1;
            for (int l = 0; l < int'(P); l++) in_data[l*W +: W] = frm[b * int'(P) + l];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_start = 1'b0;
            in_data  = {P{32'($urandom)}};
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && sb.size() > 0; k++) idle(1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout beats left %0d exp 0", sb.size());
            sb.delete();
        end
        idle(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_start !== 1'b0) begin errors++; $display("FAIL reset_out_start got %b exp 0", out_start); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL reset_out_data lane0 got %h exp 0", out_data[W-1:0]); end
        rst = 1'b0;
        mon_on = 1'b1;
    endtask

    task automatic test_latency();
        start_q.delete();
        while (cyc < 98) idle(1);
        load_const(32'hFFFF_FFFF);
        send_frame(16, 1'b1);
        wait_drain();
        checks++;
        if (start_q.size() != 1) begin
            errors++; $display("FAIL latency_frames got %0d exp 1", start_q.size());
        end else begin
            checks++;
            if (start_q[0] != 116) begin errors++; $display("FAIL latency_cycle got %0d exp 116", start_q[0]); end
        end
        checks++;
        if (cap[3] !== {FW{1'b1}}) begin errors++; $display("FAIL all_ones_beat3 lane0 got %h exp ffffffff", cap[3][W-1:0]); end
    endtask

    task automatic test_ramp();
        start_q.delete();
        load_ramp(0);
        send_frame(16, 1'b1);
        wait_drain();
        checks++;
        if (cap[0][0 +: W] !== 32'd0) begin errors++; $display("FAIL ramp_b0_l0 got %0d exp 0", cap[0][0 +: W]); end
        checks++;
        if (cap[0][W +: W] !== 32'd256) begin errors++; $display("FAIL ramp_b0_l1 got %0d exp 256", cap[0][W +: W]); end
        checks++;
        if (cap[0][2*W +: W] !== 32'd128) begin errors++; $display("FAIL ramp_b0_l2 got %0d exp 128", cap[0][2*W +: W]); end
        checks++;
        if (cap[8][0 +: W] !== 32'd1) begin errors++; $display("FAIL ramp_b8_l0 got %0d exp 1", cap[8][0 +: W]); end
        checks++;
        if (last_run != 16) begin errors++; $display("FAIL ramp_valid_run got %0d exp 16", last_run); end
        checks++;
        if (start_q.size() != 1) begin errors++; $display("FAIL ramp_frames got %0d exp 1", start_q.size()); end
    endtask

    task automatic test_back_to_back();
        start_q.delete();
        load_ramp(0);
        send_frame(16, 1'b1);
        load_ramp(1000);
        send_frame(16, 1'b1);
        wait_drain();
        checks++;
        if (last_run != 32) begin errors++; $display("FAIL b2b_valid_run got %0d exp 32", last_run); end
        checks++;
        if (cap[0][W +: W] !== 32'd1256) begin errors++; $display("FAIL b2b_beat16_l1 got %0d exp 1256", cap[0][W +: W]); end
        checks++;
        if (start_q.size() != 2) begin
            errors++; $display("FAIL b2b_frames got %0d exp 2", start_q.size());
        end else begin
            checks++;
            if (start_q[1] - start_q[0] != 16) begin errors++; $display("FAIL b2b_start_spacing got %0d exp 16", start_q[1] - start_q[0]); end
        end
    endtask

    task automatic test_abort();
        start_q.delete();
        dead_seen = 1'b0;
        load_const(32'h0000_DEAD);
        send_frame(5, 1'b0);
        load_ramp(0);
        send_frame(16, 1'b1);
        wait_drain();
        idle(20);
        checks++;
        if (start_q.size() != 1) begin errors++; $display("FAIL abort_frames got %0d exp 1", start_q.size()); end
        checks++;
        if (dead_seen) begin errors++; $display("FAIL abort_dead_leak got 1 exp 0"); end
        checks++;
        if (cap[0][W +: W] !== 32'd256) begin errors++; $display("FAIL abort_b0_l1 got %0d exp 256", cap[0][W +: W]); end
    endtask

    task automatic test_idle_gap();
        start_q.delete();
        load_ramp(0);
        send_frame(16, 1'b1);
        idle(7);
        load_ramp(5000);
        send_frame(16, 1'b1);
        wait_drain();
        checks++;
        if (start_q.size() != 2) begin
            errors++; $display("FAIL gap_frames got %0d exp 2", start_q.size());
        end else begin
            checks++;
            if (start_q[1] - start_q[0] != 23) begin errors++; $display("FAIL gap_start_spacing got %0d exp 23", start_q[1] - start_q[0]); end
        end
        checks++;
        if (last_run != 16) begin errors++; $display("FAIL gap_valid_run got %0d exp 16", last_run); end
    endtask

    task automatic test_reset_mid_output();
        bit seen;
        start_q.delete();
        load_ramp(0);
        send_frame(16, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            idle(1);
            if (out_start === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL rstmid_no_output got 0 exp 1");
            sb.delete();
        end else begin
            repeat (5) @(posedge clk);
            #1;
            rst = 1'b1;
            while (sb.size() > 1) void'(sb.pop_back());
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", out_valid); end
            checks++;
            if (out_data !== '0) begin errors++; $display("FAIL rstmid_data lane0 got %h exp 0", out_data[W-1:0]); end
            rst = 1'b0;
        end
        sb.delete();
        idle(3);
        start_q.delete();
        load_ramp(77);
        send_frame(16, 1'b1);
        wait_drain();
        checks++;
        if (start_q.size() != 1) begin
            errors++; $display("FAIL rstmid_frames got %0d exp 1", start_q.size());
        end else begin
            checks++;
            if (start_q[0] != last_start_cyc + 16) begin
                errors++; $display("FAIL rstmid_latency got %0d exp %0d", start_q[0], last_start_cyc + 16);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_ramp();
        test_back_to_back();
        test_abort();
        test_idle_gap();
        test_reset_mid_output();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
